// File: rtl/io_board_bridge.sv
// Board IO bridge: debounced switch/button bus in (DEBOUNCE_CYCLES+2 latency), registered LED/7-seg out (1 cycle).
// No flow control. Optional BRIGHTNESS_PWM_EN macro gates the output registers with a 16-step duty cycle.
module io_board_bridge #(
    parameter int IO_INPUT_BUS_LEN  = 14,
    parameter int IO_OUTPUT_BUS_LEN = 52,
    parameter int NUM_SWITCHES      = 10,
    parameter int NUM_BUTTONS       = 4,
    parameter int NUM_LEDS          = 10,
    parameter int NUM_DIGITS        = 6,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int PWM_DUTY          = 15
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_SWITCHES-1:0]      sw_raw,
    input  logic [NUM_BUTTONS-1:0]       btn_n_raw,
    output logic [IO_INPUT_BUS_LEN-1:0]  io_input_bus,
    input  logic [IO_OUTPUT_BUS_LEN-1:0] io_output_bus,
    output logic [NUM_LEDS-1:0]          led,
    output logic [7*NUM_DIGITS-1:0]      hex_n
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (NUM_SWITCHES + NUM_BUTTONS != IO_INPUT_BUS_LEN) begin : g_err_in_len
            $error("io_board_bridge: NUM_SWITCHES+NUM_BUTTONS must equal IO_INPUT_BUS_LEN");
        end
        if (NUM_LEDS + 7 * NUM_DIGITS != IO_OUTPUT_BUS_LEN) begin : g_err_out_len
            $error("io_board_bridge: NUM_LEDS+7*NUM_DIGITS must equal IO_OUTPUT_BUS_LEN");
        end
        if (DEBOUNCE_CYCLES < 2) begin : g_err_debounce
            $error("io_board_bridge: DEBOUNCE_CYCLES must be >= 2");
        end
        if (PWM_DUTY < 0 || PWM_DUTY > 15) begin : g_err_duty
            $error("io_board_bridge: PWM_DUTY must be in 0..15");
        end
    endgenerate

    // Buttons are normalised ahead of the synchroniser so a cleared flop reads as
    // "released"; an idle board then produces no spurious transitions after reset.
    logic [IO_INPUT_BUS_LEN-1:0] w_raw;
    logic [IO_INPUT_BUS_LEN-1:0] r_sync1;
    logic [IO_INPUT_BUS_LEN-1:0] r_sync2;
    logic [IO_INPUT_BUS_LEN-1:0] r_stable;
    logic [CNT_W-1:0]            r_cnt [IO_INPUT_BUS_LEN];

    assign w_raw = {~btn_n_raw, sw_raw};

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int i = 0; i < IO_INPUT_BUS_LEN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < IO_INPUT_BUS_LEN; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign io_input_bus = r_stable;

    logic w_on;
`ifdef BRIGHTNESS_PWM_EN
    logic [3:0] r_pwm_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    assign w_on = ({1'b0, r_pwm_cnt} < 5'(PWM_DUTY));
`else
    assign w_on = 1'b1;
`endif

    logic [7*NUM_DIGITS-1:0] w_seg;
    assign w_seg = io_output_bus[IO_OUTPUT_BUS_LEN-1:NUM_LEDS];

    always_ff @(posedge clock) begin
        if (!reset) begin
            led   <= '0;
            hex_n <= '1;
        end else if (w_on) begin
            led   <= io_output_bus[NUM_LEDS-1:0];
            hex_n <= ~w_seg;
        end else begin
            led   <= '0;
            hex_n <= '1;
        end
    end

endmodule

// File: tb/tb_io_board_bridge.sv
// Bench for io_board_bridge with DEBOUNCE_CYCLES=4: directed sequences, output-map table, randomized model check.
module tb_io_board_bridge;

    localparam int D    = 4;
    localparam int DUTY = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  sw_raw;
    logic [3:0]  btn_n_raw;
    logic [13:0] io_input_bus;
    logic [51:0] io_output_bus;
    logic [9:0]  led;
    logic [41:0] hex_n;

    always #5 clock = ~clock;

    io_board_bridge #(
        .DEBOUNCE_CYCLES(D),
        .PWM_DUTY       (DUTY)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sw_raw       (sw_raw),
        .btn_n_raw    (btn_n_raw),
        .io_input_bus (io_input_bus),
        .io_output_bus(io_output_bus),
        .led          (led),
        .hex_n        (hex_n)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a bit is accepted once the synchronised level has differed
    // from the accepted level on the last D consecutive edges.
    logic [13:0] m_s1, m_s2, m_stable;
    logic [13:0] m_hist [D];
    logic [9:0]  m_led;
    logic [41:0] m_hex;
    int          m_pwm;
    bit          m_on;
    bit          m_all;

    always @(posedge clock) begin
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0;
            for (int i = 0; i < D; i++) m_hist[i] = '0;
            m_led = '0; m_hex = '1; m_pwm = 0; m_on = 1'b0;
        end else begin
            for (int i = D - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = m_s2;
            for (int b = 0; b < 14; b++) begin
                m_all = 1'b1;
                for (int i = 0; i < D; i++)
                    if (m_hist[i][b] == m_stable[b]) m_all = 1'b0;
                if (m_all) m_stable[b] = ~m_stable[b];
            end
            m_s2 = m_s1;
            m_s1 = {~btn_n_raw, sw_raw};
`ifdef BRIGHTNESS_PWM_EN
            m_on = (m_pwm % 16) < DUTY;
`else
            m_on = 1'b1;
`endif
            m_pwm = m_pwm + 1;
            m_led = m_on ? io_output_bus[9:0] : 10'h0;
            for (int k = 0; k < 6; k++)
                m_hex[7*k +: 7] = m_on ? ~io_output_bus[10 + 7*k +: 7] : 7'h7F;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    typedef struct {
        logic [51:0] bus;
        logic [9:0]  led;
        logic [41:0] hex;
    } vec_t;

    vec_t        tbl [5];
    logic [51:0] rbus;
    int          lit_cnt;

    initial begin
        tbl[0] = '{bus: {7'h3F, 35'h0, 10'h2A5},        led: 10'h2A5, hex: {7'h40, {35{1'b1}}}};
        tbl[1] = '{bus: 52'h0,                          led: 10'h000, hex: {42{1'b1}}};
        tbl[2] = '{bus: {52{1'b1}},                     led: 10'h3FF, hex: 42'h0};
        tbl[3] = '{bus: {35'h0, 7'h06, 10'h000},        led: 10'h000, hex: {{35{1'b1}}, 7'h79}};
        tbl[4] = '{bus: {21'h0, 7'h5B, 14'h0, 10'h155}, led: 10'h155, hex: {{21{1'b1}}, 7'h24, {14{1'b1}}}};

        // Reset with every input asserted, then exact re-qualification time.
        reset = 1'b0; sw_raw = 10'h3FF; btn_n_raw = 4'h0; io_output_bus = {7'h3F, 35'h0, 10'h2A5};
        repeat (3) step();
        chk("rst_in", io_input_bus, 14'h0);
        chk("rst_led", led, 10'h0);
        chk("rst_hex", hex_n, {42{1'b1}});
        reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("rst_requal", io_input_bus, (k >= 6) ? 14'h3FFF : 14'h0);
        end

        // Mid-operation reset drops held inputs.
        reset = 1'b0;
        step();
        chk("midrst_in", io_input_bus, 14'h0);
        reset = 1'b1;

        // Single switch accepted after exactly D+2 edges.
        sw_raw = 10'h0; btn_n_raw = 4'hF; io_output_bus = '0;
        do_reset(); repeat (3) step();
        sw_raw[3] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("deb_accept", io_input_bus, (k >= 6) ? 14'h0008 : 14'h0);
        end

        // Short button glitch rejected, long press accepted and released.
        sw_raw = 10'h0;
        do_reset(); repeat (3) step();
        btn_n_raw[1] = 1'b0;
        for (int k = 1; k <= 3; k++) begin step(); chk("glitch_low", io_input_bus, 14'h0); end
        btn_n_raw[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin step(); chk("glitch_after", io_input_bus, 14'h0); end
        btn_n_raw[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("press", io_input_bus, (k >= 6) ? 14'h0800 : 14'h0);
        end
        btn_n_raw[1] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("release", io_input_bus, (k >= 6) ? 14'h0 : 14'h0800);
        end

        // Output map table: registered image, then hold with the bus unchanged.
        for (int i = 0; i < 5; i++) begin
            io_output_bus = tbl[i].bus;
            step();
            chk("map_led", led, m_on ? tbl[i].led : 10'h0);
            chk("map_hex", hex_n, m_on ? tbl[i].hex : {42{1'b1}});
            step();
            chk("hold_led", led, m_on ? tbl[i].led : 10'h0);
            chk("hold_hex", hex_n, m_on ? tbl[i].hex : {42{1'b1}});
        end

        // Simultaneous switch and button change while the output bus moves every cycle.
        sw_raw = 10'h0; btn_n_raw = 4'hF; io_output_bus = '0;
        do_reset(); repeat (2) step();
        sw_raw = 10'h001; btn_n_raw = 4'b1110;
        for (int k = 1; k <= 8; k++) begin
            rbus = {$urandom, $urandom};
            io_output_bus = rbus;
            step();
            chk("simul_in", io_input_bus, (k >= 6) ? 14'h0401 : 14'h0);
            chk("simul_led", led, m_on ? rbus[9:0] : 10'h0);
        end

        // Brightness: count lit cycles over two full PWM periods.
        io_output_bus = {42'h0, 10'h3FF};
        step();
        lit_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            if (led == 10'h3FF) lit_cnt++;
            chk("pwm_level", led, m_on ? 10'h3FF : 10'h0);
        end
`ifdef BRIGHTNESS_PWM_EN
        chk("pwm_lit_count", lit_cnt, 2 * DUTY);
`else
        chk("pwm_lit_count", lit_cnt, 32);
`endif

        // Randomized phase against the reference model, with occasional resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            for (int b = 0; b < 10; b++)
                if ($urandom_range(0, 7) == 0) sw_raw[b] = ~sw_raw[b];
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) btn_n_raw[b] = ~btn_n_raw[b];
            io_output_bus = {$urandom, $urandom};
            step();
            chk("rand_in", io_input_bus, m_stable);
            chk("rand_led", led, m_led);
            chk("rand_hex", hex_n, m_hex);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
